bloom_query: RTL and testbench

- Read-side companion to the Bloom insert path.
- Accepts membership queries over a valid/ready handshake and snapshots the current filter vector.
- Probes the filter one hash index per cycle, exiting early on the first zero bit, then returns a hit/miss response over a second valid/ready handshake.
- Keeps saturating query and hit counters for debug and statistics readout.

---
 rtl/bloom_query.sv | 147 ++++++++++++++
 tb/tb_bloom_query.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/bloom_query.sv
// Bloom filter membership query engine: snapshots the filter on accept, probes
// one hash index per cycle with early exit on a zero bit, and keeps saturating stats.
module bloom_query #(
  parameter int d_size   = 8,
  parameter int bl_size  = 32,
  parameter int num_hash = 3,
  parameter int cnt_w    = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [bl_size-1:0] bl_in,
  input  logic [d_size-1:0]  q_data,
  input  logic               q_valid,
  output logic               q_ready,
  output logic               r_valid,
  input  logic               r_ready,
  output logic               r_match,
  output logic               busy,
  output logic [cnt_w-1:0]   q_count,
  output logic [cnt_w-1:0]   hit_count
);

  localparam int IW = $clog2(bl_size);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PROBE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  localparam logic [1:0] LAST_I = 2'(num_hash - 1);

  logic [1:0]         state_q, state_d;
  logic [d_size-1:0]  key_q, key_d;
  logic [bl_size-1:0] snap_q, snap_d;
  logic [1:0]         i_q, i_d;
  logic               pend_q, pend_d;
  logic               bit_q, bit_d;
  logic               match_q, match_d;
  logic [cnt_w-1:0]   q_count_q, q_count_d;
  logic [cnt_w-1:0]   hit_count_q, hit_count_d;

  logic [IW-1:0]      h [4];
  logic [1:0]         sel;
  logic               probe_bit;

  function automatic logic [IW-1:0] hash_idx(input logic [d_size-1:0] key, input int k);
    logic [2*d_size-1:0] dbl;
    logic [d_size-1:0]   rot;
    logic [d_size-1:0]   salt;
    int                  amt;
    amt  = (3 * k) % d_size;
    dbl  = {key, key} << amt;
    rot  = dbl[2*d_size-1 -: d_size];
    salt = d_size'(k * 91);
    return IW'(rot ^ salt);
  endfunction

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      h[k] = hash_idx(key_q, k);
    end
  end

  // The probed bit is registered, so each probe decision lands one cycle after its fetch.
  assign sel       = pend_q ? (i_q + 2'd1) : i_q;
  assign probe_bit = snap_q[h[sel]];

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    snap_d      = snap_q;
    i_d         = i_q;
    pend_d      = pend_q;
    bit_d       = bit_q;
    match_d     = match_q;
    q_count_d   = q_count_q;
    hit_count_d = hit_count_q;
    case (state_q)
      S_IDLE: begin
        if (q_valid) begin
          state_d = S_PROBE;
          key_d   = q_data;
          snap_d  = bl_in;
          i_d     = 2'd0;
          pend_d  = 1'b0;
          match_d = 1'b0;
          if (q_count_q != {cnt_w{1'b1}}) q_count_d = q_count_q + cnt_w'(1);
        end
      end
      S_PROBE: begin
        if (!pend_q) begin
          bit_d  = probe_bit;
          pend_d = 1'b1;
        end else if (!bit_q) begin
          match_d = 1'b0;
          pend_d  = 1'b0;
          state_d = S_RESP;
        end else if (i_q == LAST_I) begin
          match_d = 1'b1;
          pend_d  = 1'b0;
          state_d = S_RESP;
        end else begin
          i_d   = i_q + 2'd1;
          bit_d = probe_bit;
        end
      end
      S_RESP: begin
        if (r_ready) begin
          state_d = S_IDLE;
          if (match_q && (hit_count_q != {cnt_w{1'b1}})) hit_count_d = hit_count_q + cnt_w'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      key_q       <= '0;
      snap_q      <= '0;
      i_q         <= '0;
      pend_q      <= 1'b0;
      bit_q       <= 1'b0;
      match_q     <= 1'b0;
      q_count_q   <= '0;
      hit_count_q <= '0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      snap_q      <= snap_d;
      i_q         <= i_d;
      pend_q      <= pend_d;
      bit_q       <= bit_d;
      match_q     <= match_d;
      q_count_q   <= q_count_d;
      hit_count_q <= hit_count_d;
    end
  end

  assign q_ready   = (state_q == S_IDLE);
  assign r_valid   = (state_q == S_RESP);
  assign r_match   = r_valid & match_q;
  assign busy      = (state_q != S_IDLE);
  assign q_count   = q_count_q;
  assign hit_count = hit_count_q;

endmodule

// File: tb/tb_bloom_query.sv
// Directed bench for bloom_query: hand-computed hash hits/misses, snapshot, backpressure,
// mid-probe reset, and counter saturation on a narrow-counter instance.
module tb_bloom_query;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] bl_in;
  logic [7:0]  q_data;
  logic        q_valid;
  logic        q_ready;
  logic        r_valid;
  logic        r_ready;
  logic        r_match;
  logic        busy;
  logic [15:0] q_count;
  logic [15:0] hit_count;

  logic [7:0]  s_q_data;
  logic        s_q_valid;
  logic        s_q_ready;
  logic        s_r_valid;
  logic        s_r_ready;
  logic        s_r_match;
  logic        s_busy;
  logic [0:0]  s_q_count;
  logic [0:0]  s_hit_count;

  int num_checks = 0;
  int num_errors = 0;
  int lat;

  always #5 clk = ~clk;

  bloom_query dut (
    .clk(clk), .reset_n(reset_n), .bl_in(bl_in), .q_data(q_data),
    .q_valid(q_valid), .q_ready(q_ready), .r_valid(r_valid), .r_ready(r_ready),
    .r_match(r_match), .busy(busy), .q_count(q_count), .hit_count(hit_count)
  );

  bloom_query #(.cnt_w(1)) dut_sat (
    .clk(clk), .reset_n(reset_n), .bl_in(bl_in), .q_data(s_q_data),
    .q_valid(s_q_valid), .q_ready(s_q_ready), .r_valid(s_r_valid), .r_ready(s_r_ready),
    .r_match(s_r_match), .busy(s_busy), .q_count(s_q_count), .hit_count(s_hit_count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers a key, waits for acceptance, then counts cycles until r_valid appears.
  task automatic applyStimulus(input logic [7:0] key, output int latency);
    int n;
    q_data  = key;
    q_valid = 1'b1;
    n = 0;
    while (!q_ready && n < 20) begin
      step();
      n++;
    end
    step();
    q_valid = 1'b0;
    latency = 0;
    while (!r_valid && latency < 20) begin
      step();
      latency++;
    end
  endtask

  task automatic consume();
    r_ready = 1'b1;
    step();
    r_ready = 1'b0;
  endtask

  task automatic query_check(input string tag, input logic [7:0] key,
                             input int exp_lat, input logic exp_match);
    applyStimulus(key, lat);
    checkOutput({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, "_valid"}, 32'(r_valid), 32'd1);
    checkOutput({tag, "_match"}, 32'(r_match), 32'(exp_match));
    consume();
  endtask

  task automatic sat_query(input string tag, input logic exp_q, input logic exp_hit);
    int n;
    s_q_valid = 1'b1;
    n = 0;
    while (!s_q_ready && n < 20) begin
      step();
      n++;
    end
    step();
    s_q_valid = 1'b0;
    checkOutput({tag, "_qcnt"}, 32'(s_q_count), 32'(exp_q));
    n = 0;
    while (s_busy && n < 20) begin
      step();
      n++;
    end
    checkOutput({tag, "_idle"}, 32'(s_busy), 32'd0);
    checkOutput({tag, "_hitcnt"}, 32'(s_hit_count), 32'(exp_hit));
  endtask

  initial begin
    reset_n   = 1'b0;
    bl_in     = 32'h0;
    q_data    = 8'h0;
    q_valid   = 1'b0;
    r_ready   = 1'b0;
    s_q_data  = 8'h0;
    s_q_valid = 1'b0;
    s_r_ready = 1'b1;
    #12;
    checkOutput("rst_r_valid", 32'(r_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_q_count", 32'(q_count), 32'd0);
    checkOutput("rst_hit_count", 32'(hit_count), 32'd0);
    step();
    reset_n = 1'b1;
    step();
    checkOutput("rel_q_ready", 32'(q_ready), 32'd1);

    // Key 00 probes 0, 27, 22; key 01 probes 1 first.
    bl_in = 32'h0840_0001;
    query_check("hit00", 8'h00, 4, 1'b1);
    checkOutput("hit00_hitcnt", 32'(hit_count), 32'd1);
    checkOutput("hit00_qcnt", 32'(q_count), 32'd1);
    checkOutput("hit00_busy", 32'(busy), 32'd0);
    checkOutput("hit00_q_ready", 32'(q_ready), 32'd1);

    query_check("miss01", 8'h01, 2, 1'b0);
    checkOutput("miss01_hitcnt", 32'(hit_count), 32'd1);
    checkOutput("miss01_qcnt", 32'(q_count), 32'd2);

    // Filter cleared right after acceptance must not change the answer.
    q_data  = 8'h00;
    q_valid = 1'b1;
    step();
    q_valid = 1'b0;
    bl_in   = 32'h0;
    lat = 0;
    while (!r_valid && lat < 20) begin
      step();
      lat++;
    end
    checkOutput("snap_lat", 32'(lat), 32'd4);
    checkOutput("snap_match", 32'(r_match), 32'd1);
    consume();
    checkOutput("snap_hitcnt", 32'(hit_count), 32'd2);
    bl_in = 32'h0840_0001;

    // Backpressure: response held while a new query is offered and ignored.
    applyStimulus(8'h00, lat);
    checkOutput("bp_lat", 32'(lat), 32'd4);
    q_data  = 8'h01;
    q_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      checkOutput("bp_r_valid", 32'(r_valid), 32'd1);
      checkOutput("bp_r_match", 32'(r_match), 32'd1);
      checkOutput("bp_q_ready", 32'(q_ready), 32'd0);
    end
    checkOutput("bp_qcnt_hold", 32'(q_count), 32'd4);
    r_ready = 1'b1;
    step();
    r_ready = 1'b0;
    checkOutput("bp_rel_q_ready", 32'(q_ready), 32'd1);
    checkOutput("bp_rel_r_valid", 32'(r_valid), 32'd0);
    checkOutput("bp_rel_qcnt", 32'(q_count), 32'd4);
    checkOutput("bp_rel_hitcnt", 32'(hit_count), 32'd3);
    step();
    q_valid = 1'b0;
    checkOutput("bp_next_qcnt", 32'(q_count), 32'd5);
    checkOutput("bp_next_busy", 32'(busy), 32'd1);
    lat = 0;
    while (!r_valid && lat < 20) begin
      step();
      lat++;
    end
    checkOutput("bp_next_lat", 32'(lat), 32'd2);
    checkOutput("bp_next_match", 32'(r_match), 32'd0);
    consume();
    checkOutput("bp_next_hitcnt", 32'(hit_count), 32'd3);

    bl_in = 32'hFFFF_FFFF;
    query_check("ones5a", 8'h5A, 3 + 1, 1'b1);
    bl_in = 32'h0;
    query_check("zero5a", 8'h5A, 2, 1'b0);
    checkOutput("bound_qcnt", 32'(q_count), 32'd7);
    checkOutput("bound_hitcnt", 32'(hit_count), 32'd4);

    // Reset asserted in the middle of a probe sequence.
    bl_in   = 32'hFFFF_FFFF;
    q_data  = 8'h00;
    q_valid = 1'b1;
    step();
    q_valid = 1'b0;
    step();
    checkOutput("mid_busy_pre", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("mid_r_valid", 32'(r_valid), 32'd0);
    checkOutput("mid_r_match", 32'(r_match), 32'd0);
    checkOutput("mid_busy", 32'(busy), 32'd0);
    checkOutput("mid_qcnt", 32'(q_count), 32'd0);
    checkOutput("mid_hitcnt", 32'(hit_count), 32'd0);
    step();
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      checkOutput("post_rst_r_valid", 32'(r_valid), 32'd0);
    end
    checkOutput("post_rst_q_ready", 32'(q_ready), 32'd1);

    // One-bit counters on the second instance saturate at 1.
    sat_query("sat1", 1'b1, 1'b1);
    sat_query("sat2", 1'b1, 1'b1);
    sat_query("sat3", 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
